// File: rtl/axi_lite_reg_file_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) for the register-file slave.
interface axi_lite_reg_file_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_reg_file_slave.sv
// AXI4-Lite slave front-end for a register file: independent write and read
// FSMs, word-aligned index decode, single-cycle register strobes, OKAY/SLVERR.
// Optional feature macro: AXI_LITE_REG_FILE_SLAVE_WSTRB_EN (pass wstrb through
// to reg_wr_strb; when undefined every write is full-word).
module axi_lite_reg_file_slave #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16,
    localparam int STRB_W  = DATA_W / 8,
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_lite_reg_file_slave_if.slave s_axi,
    output logic                 reg_wr_en,
    output logic [IDX_W-1:0]     reg_wr_idx,
    output logic [DATA_W-1:0]    reg_wr_data,
    output logic [STRB_W-1:0]    reg_wr_strb,
    output logic                 reg_rd_en,
    output logic [IDX_W-1:0]     reg_rd_idx,
    input  logic [DATA_W-1:0]    reg_rd_data
);
    localparam int LSB    = $clog2(STRB_W);
    localparam int FULL_W = ADDR_W - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_CAP, R_RESP} rd_state_e;

    // Full word index (all address bits above the byte offset) and range checks
    logic [FULL_W-1:0] aw_full;
    logic [FULL_W-1:0] ar_full;
    logic              aw_in_range;
    logic              ar_in_range;

    assign aw_full     = s_axi.s_axi_awaddr[ADDR_W-1:LSB];
    assign ar_full     = s_axi.s_axi_araddr[ADDR_W-1:LSB];
    assign aw_in_range = 32'(aw_full) < 32'(NUM_REGS);
    assign ar_in_range = 32'(ar_full) < 32'(NUM_REGS);

    // Byte-offset bits are deliberately ignored (unaligned addresses are not flagged)
    logic unused_addr_lsbs;
`ifdef AXI_LITE_REG_FILE_SLAVE_WSTRB_EN
    assign unused_addr_lsbs = ^{s_axi.s_axi_awaddr[LSB-1:0], s_axi.s_axi_araddr[LSB-1:0]};
`else
    assign unused_addr_lsbs = ^{s_axi.s_axi_awaddr[LSB-1:0], s_axi.s_axi_araddr[LSB-1:0],
                                s_axi.s_axi_wstrb};
`endif

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              wr_ok_q, wr_ok_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs;
    logic              w_hs;

    // Readies are gated by rst so they read 0 during reset and 1 as soon as it falls
    assign s_axi.s_axi_awready = !rst && (wr_state_q == W_IDLE) && !aw_got_q;
    assign s_axi.s_axi_wready  = !rst && (wr_state_q == W_IDLE) && !w_got_q;
    assign s_axi.s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi.s_axi_bresp   = bresp_q;

    assign aw_hs = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_hs  = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;

    assign reg_wr_en   = (wr_state_q == W_EXEC) && wr_ok_q;
    assign reg_wr_idx  = wr_idx_q;
    assign reg_wr_data = wr_data_q;
    assign reg_wr_strb = wr_strb_q;

    // Write FSM state and latched AW/W payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_ok_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            wr_idx_q   <= wr_idx_d;
            wr_ok_q    <= wr_ok_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Write FSM next state: collect AW and W in any order, strobe, then respond
    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        wr_idx_d   = wr_idx_q;
        wr_ok_d    = wr_ok_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    wr_idx_d = aw_full[IDX_W-1:0];
                    wr_ok_d  = aw_in_range;
                end
                if (w_hs) begin
                    w_got_d   = 1'b1;
                    wr_data_d = s_axi.s_axi_wdata;
`ifdef AXI_LITE_REG_FILE_SLAVE_WSTRB_EN
                    wr_strb_d = s_axi.s_axi_wstrb;
`else
                    wr_strb_d = '1;
`endif
                end
                // Both flags clear on leaving IDLE; readies stay low via the state check
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    wr_state_d = W_EXEC;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                end
            end
            W_EXEC: begin
                bresp_d    = wr_ok_q ? RESP_OKAY : RESP_SLVERR;
                wr_state_d = W_RESP;
            end
            W_RESP: begin
                if (s_axi.s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              rd_ok_q, rd_ok_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ar_hs;

    assign s_axi.s_axi_arready = !rst && (rd_state_q == R_IDLE);
    assign s_axi.s_axi_rvalid  = (rd_state_q == R_RESP);
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

    assign ar_hs = s_axi.s_axi_arvalid && s_axi.s_axi_arready;

    assign reg_rd_en  = (rd_state_q == R_EXEC) && rd_ok_q;
    assign reg_rd_idx = rd_idx_q;

    // Read FSM state and captured response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_ok_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_ok_q    <= rd_ok_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Read FSM next state: latch index, strobe, capture one cycle later, respond
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_ok_d    = rd_ok_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_idx_d   = ar_full[IDX_W-1:0];
                    rd_ok_d    = ar_in_range;
                    rd_state_d = R_EXEC;
                end
            end
            R_EXEC: rd_state_d = R_CAP;
            R_CAP: begin
                rdata_d    = rd_ok_q ? reg_rd_data : '0;
                rresp_d    = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
                rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (s_axi.s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_reg_file_slave.sv
// Directed self-checking bench for axi_lite_reg_file_slave (DATA_W=32, ADDR_W=12, NUM_REGS=16).
module tb_axi_lite_reg_file_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_en;
    logic [3:0]  reg_wr_idx;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_rd_en;
    logic [3:0]  reg_rd_idx;
    logic [31:0] reg_rd_data;
    logic [31:0] rf_value;

    int tests = 0;
    int fails = 0;
    int wr_count;

    axi_lite_reg_file_slave_if #(.DATA_W(32), .ADDR_W(12)) bus ();

    axi_lite_reg_file_slave #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axi       (bus),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_idx  (reg_wr_idx),
        .reg_wr_data (reg_wr_data),
        .reg_wr_strb (reg_wr_strb),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_idx  (reg_rd_idx),
        .reg_rd_data (reg_rd_data)
    );

    always #5 clk = ~clk;

    // Register-file read port model: data is valid only the cycle after reg_rd_en
    always @(posedge clk) reg_rd_data <= reg_rd_en ? rf_value : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rf_value = 32'h12345678;
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
        step(); step();

        // Reset: every output 0 while rst is high
        chk("rst_awready", bus.s_axi_awready, 0);
        chk("rst_wready", bus.s_axi_wready, 0);
        chk("rst_arready", bus.s_axi_arready, 0);
        chk("rst_bvalid", bus.s_axi_bvalid, 0);
        chk("rst_wr_strb", reg_wr_strb, 0);

        // Release: readies up in the first cycle, everything else still 0
        rst = 1'b0;
        #1;
        chk("rel_awready", bus.s_axi_awready, 1);
        chk("rel_wready", bus.s_axi_wready, 1);
        chk("rel_arready", bus.s_axi_arready, 1);
        chk("rel_wr_en", reg_wr_en, 0);
        chk("rel_rd_en", reg_rd_en, 0);
        chk("rel_rvalid", bus.s_axi_rvalid, 0);
        chk("rel_rdata", bus.s_axi_rdata, 0);
        step();

        // Simultaneous AW=0x008 / W=0xDEADBEEF
        bus.s_axi_awaddr = 12'h008; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'hDEADBEEF; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        chk("t2_wr_en", reg_wr_en, 1);
        chk("t2_wr_idx", reg_wr_idx, 2);
        chk("t2_wr_data", reg_wr_data, 32'hDEADBEEF);
        chk("t2_wr_strb", reg_wr_strb, 4'hF);
        chk("t2_bvalid_t1", bus.s_axi_bvalid, 0);
        chk("t2_awready_t1", bus.s_axi_awready, 0);
        step();
        chk("t2_bvalid", bus.s_axi_bvalid, 1);
        chk("t2_bresp", bus.s_axi_bresp, 2'b00);
        chk("t2_wr_en_t2", reg_wr_en, 0);
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        chk("t2_bvalid_done", bus.s_axi_bvalid, 0);
        chk("t2_awready_back", bus.s_axi_awready, 1);

        // W first, AW=0x00C three cycles later, bready held low 4 cycles
        wr_count = 0;
        bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        step();
        bus.s_axi_wvalid = 1'b0;
        wr_count += int'(reg_wr_en);
        chk("t3_wready_lo", bus.s_axi_wready, 0);
        chk("t3_awready_hi", bus.s_axi_awready, 1);
        step();
        wr_count += int'(reg_wr_en);
        step();
        wr_count += int'(reg_wr_en);
        bus.s_axi_awaddr = 12'h00C; bus.s_axi_awvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0;
        wr_count += int'(reg_wr_en);
        chk("t3_wr_en", reg_wr_en, 1);
        chk("t3_wr_idx", reg_wr_idx, 3);
        chk("t3_wr_data", reg_wr_data, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            step();
            wr_count += int'(reg_wr_en);
            chk("t3_bvalid_held", bus.s_axi_bvalid, 1);
            chk("t3_wready_held", bus.s_axi_wready, 0);
        end
        chk("t3_bresp", bus.s_axi_bresp, 2'b00);
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        wr_count += int'(reg_wr_en);
        chk("t3_bvalid_done", bus.s_axi_bvalid, 0);
        chk("t3_wready_back", bus.s_axi_wready, 1);
        chk("t3_wr_en_count", wr_count, 1);

        // Read AR=0x004, register file returns 0x12345678
        bus.s_axi_araddr = 12'h004; bus.s_axi_arvalid = 1'b1;
        step();
        bus.s_axi_arvalid = 1'b0;
        chk("t4_rd_en", reg_rd_en, 1);
        chk("t4_rd_idx", reg_rd_idx, 1);
        chk("t4_arready_lo", bus.s_axi_arready, 0);
        step();
        chk("t4_rd_en_t2", reg_rd_en, 0);
        chk("t4_rvalid_t2", bus.s_axi_rvalid, 0);
        step();
        chk("t4_rvalid", bus.s_axi_rvalid, 1);
        chk("t4_rdata", bus.s_axi_rdata, 32'h12345678);
        chk("t4_rresp", bus.s_axi_rresp, 2'b00);
        step();
        chk("t4_rvalid_held", bus.s_axi_rvalid, 1);
        chk("t4_rdata_held", bus.s_axi_rdata, 32'h12345678);
        bus.s_axi_rready = 1'b1;
        step();
        bus.s_axi_rready = 1'b0;
        chk("t4_rvalid_done", bus.s_axi_rvalid, 0);
        chk("t4_arready_back", bus.s_axi_arready, 1);

        // Out of range: AW=0x040, AR=0x044, both readies held high beforehand
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        bus.s_axi_awaddr = 12'h040; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h55555555; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_araddr = 12'h044; bus.s_axi_arvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        chk("t5_no_wr_en", reg_wr_en, 0);
        chk("t5_no_rd_en", reg_rd_en, 0);
        step();
        chk("t5_bvalid", bus.s_axi_bvalid, 1);
        chk("t5_bresp", bus.s_axi_bresp, 2'b10);
        step();
        chk("t5_bvalid_done", bus.s_axi_bvalid, 0);
        chk("t5_rvalid", bus.s_axi_rvalid, 1);
        chk("t5_rresp", bus.s_axi_rresp, 2'b10);
        chk("t5_rdata", bus.s_axi_rdata, 0);
        step();
        chk("t5_rvalid_done", bus.s_axi_rvalid, 0);
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;

        // Partial strobe, then reset pulse during W_RESP
        bus.s_axi_awaddr = 12'h010; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'hA5A5A5A5; bus.s_axi_wstrb = 4'h3; bus.s_axi_wvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        chk("t6_wr_idx", reg_wr_idx, 4);
`ifdef AXI_LITE_REG_FILE_SLAVE_WSTRB_EN
        chk("t6_wr_strb", reg_wr_strb, 4'h3);
`else
        chk("t6_wr_strb", reg_wr_strb, 4'hF);
`endif
        step();
        chk("t6_bvalid_pre", bus.s_axi_bvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_bvalid", bus.s_axi_bvalid, 0);
        chk("t6_rst_awready", bus.s_axi_awready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_rel_awready", bus.s_axi_awready, 1);
        bus.s_axi_awaddr = 12'h014; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h0BADF00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        chk("t6_post_wr_en", reg_wr_en, 1);
        chk("t6_post_wr_idx", reg_wr_idx, 5);
        chk("t6_post_wr_data", reg_wr_data, 32'h0BADF00D);
        step();
        chk("t6_post_bvalid", bus.s_axi_bvalid, 1);
        chk("t6_post_bresp", bus.s_axi_bresp, 2'b00);
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        chk("t6_post_done", bus.s_axi_bvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
